branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Consumes the ID-stage branch resolution (BResult) from the branch comparator and closes the loop with IF.
//  Holds a direct-mapped BTB with 2-bit saturating counters; predicts taken/target for the IF PC,
//  pipelines the prediction to ID, and on a misprediction redirects the PC and flushes IF/ID.
//  Sits between the IF PC mux and the ID branch comparator in the 5-stage MIPS pipeline.
// PARAMETERS
//  PC_W      32  PC/target width
//  IDX_W     4   BTB index bits (2**IDX_W entries); index = pc[IDX_W+1:2]
//  CNT_W     16  width of saturating mispredict performance counter
// PORTS
//  clk            in   1       pipeline clock
//  rstn           in   1       asynchronous, active-low reset
//  if_pc          in   PC_W    PC of instruction being fetched
//  pred_taken     out  1       IF: predict taken (BTB hit and counter[1]==1)
//  pred_target    out  PC_W    IF: predicted target (valid when pred_taken)
//  ifid_stall     in   1       IF/ID register held this cycle
//  id_br_valid    in   1       ID holds a decoded branch (BTypeOp valid)
//  id_pc          in   PC_W    PC of branch in ID
//  id_target      in   PC_W    computed branch target in ID
//  id_br_result   in   1       BResult from comparator; 1 = taken; ignored (may be X) when !id_br_valid
//  redirect       out  1       comb: mispredict, load PC with redirect_pc next edge
//  redirect_pc    out  PC_W    id_br_result ? id_target : id_pc+4
//  flush_ifid     out  1       comb: equals redirect; IF/ID becomes bubble
//  mispred_cnt    out  CNT_W   saturating count of mispredictions
// BEHAVIOUR
//  Reset (async, rstn=0): all entries valid=0, ctr=2'b01; pred_id=0; mispred_cnt=0. Outputs: pred_taken=0,
//   pred_target=0, redirect=0, flush_ifid=0. Reset mid-resolution discards the pending update.
//  Entry = {valid, tag=pc[PC_W-1:IDX_W+2], target, ctr[1:0]}. Lookup is combinational on if_pc; no bypass:
//   a lookup and update to the same index in one cycle returns the pre-update entry.
//  Prediction pipeline reg pred_id {taken,target}: if ifid_stall hold; else if flush_ifid load 0; else load IF pred.
//  Resolution (ID), only when id_br_valid && !ifid_stall:
//   mispredict = (id_br_result != pred_id.taken) | (id_br_result & pred_id.target != id_target).
//   redirect/flush_ifid = mispredict, same cycle (zero latency); deasserted otherwise and while stalled.
//  Update at clock edge on resolution: hit (valid & tag match) -> ctr sat +1 if taken else sat -1 (00..11, no wrap);
//   target <= id_target. Miss -> allocate: valid=1, tag, target, ctr = taken ? 2'b10 : 2'b01.
//  mispred_cnt increments on each redirect; saturates at all-ones (no wrap).
//  Stall with id_br_valid: no update, no redirect, no count until stall drops (resolved exactly once).
//  id_br_valid=0: id_br_result, id_pc, id_target ignored entirely.
// STRUCTURE
//  Shared include (Ctrl_encoding_def.v): counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11,
//   default IDX_W/PC_W.
//  Sub-module: bp_sat_ctr2 (pure next-state 2-bit saturating inc/dec), one instance on the update path.
//  BTB arrays as flop regs (not RAM) for async reset and same-cycle read.
// TESTING
//  Reset then if_pc=0x0040_0010 -> pred_taken=0; branch resolves taken, target 0x0040_0040 -> redirect=1,
//   redirect_pc=0x0040_0040, mispred_cnt=1, entry ctr=WT.
//  Re-fetch 0x0040_0010 -> pred_taken=1, pred_target=0x0040_0040; resolves taken -> redirect=0, ctr=ST.
//  From ST, resolve not-taken with pred taken -> redirect=1, redirect_pc=0x0040_0014, ctr=WT; again -> WNT.
//  Aliasing: 0x0040_0010 entry valid, fetch 0x0080_0010 (same idx, tag differs) -> pred_taken=0;
//   resolve taken -> entry replaced with new tag, ctr=WT.
//  Branch in ID with ifid_stall=1 for 3 cycles -> no redirect/update/count; on release exactly one resolution.
//  Force mispred_cnt to 0xFFFF via 65535 mispredicts (or preload) -> next mispredict leaves 0xFFFF; rstn low
//   mid-cycle -> all outputs 0 immediately, BTB invalid.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings and defaults for the branch predict unit: 2-bit
// saturating counter states and the saturating step helper.
package branch_predict_unit_pkg;

    localparam int PC_W_DEF  = 32;
    localparam int IDX_W_DEF = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // One saturating step toward taken (up=1) or not-taken (up=0); never wraps.
    function automatic ctr_e sat_step(input ctr_e c, input logic up);
        if (up)
            return (c == ST) ? ST : ctr_e'(c + 2'b01);
        else
            return (c == SNT) ? SNT : ctr_e'(c - 2'b01);
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// IF/ID-side signal bundle of the branch predict unit. The pipeline drives
// through master; the predictor sits on slave.
interface branch_predict_unit_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  if_pc;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             ifid_stall;
    logic             id_br_valid;
    logic [PC_W-1:0]  id_pc;
    logic [PC_W-1:0]  id_target;
    logic             id_br_result;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush_ifid;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output if_pc, ifid_stall, id_br_valid, id_pc, id_target, id_br_result,
        input  pred_taken, pred_target, redirect, redirect_pc, flush_ifid, mispred_cnt
    );

    modport slave (
        input  if_pc, ifid_stall, id_br_valid, id_pc, id_target, id_br_result,
        output pred_taken, pred_target, redirect, redirect_pc, flush_ifid, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_unit_sat_ctr2.sv
// Pure next-state logic for a 2-bit saturating branch counter.
module bp_sat_ctr2
    import branch_predict_unit_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctr_nxt
);
    assign ctr_nxt = sat_step(ctr, taken);
endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters. Predicts for the IF PC, carries the
// prediction to ID, and on a misprediction redirects the PC and flushes IF/ID
// in the same cycle the branch resolves.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rstn,
    branch_predict_unit_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] target;
    } pred_t;

    // BTB kept in flops so reset clears it and lookup is same-cycle
    logic [ENTRIES-1:0]             vld_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][PC_W-1:0]   tgt_q;
    logic [ENTRIES-1:0][1:0]        ctr_q;

    pred_t            pred_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IDX_W-1:0] if_idx, id_idx;
    logic [TAG_W-1:0] if_tag, id_tag;
    logic             if_hit, id_hit;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             resolve, mispredict, redirect;
    ctr_e             ctr_upd, ctr_new;

    // IF lookup: reads the pre-update entry even when ID writes the same index
    assign if_idx      = bus.if_pc[IDX_W+1:2];
    assign if_tag      = bus.if_pc[PC_W-1:IDX_W+2];
    assign if_hit      = vld_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? tgt_q[if_idx] : '0;

    // A stalled branch stays in ID and resolves once the stall drops
    assign resolve    = bus.id_br_valid && !bus.ifid_stall;
    assign mispredict = resolve &&
                        ((bus.id_br_result != pred_q.taken) ||
                         (bus.id_br_result && (pred_q.target != bus.id_target)));
    // Held low during reset so no stale resolution leaks out
    assign redirect   = mispredict && rstn;

    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign bus.redirect    = redirect;
    assign bus.flush_ifid  = redirect;
    assign bus.redirect_pc = !rstn ? '0 :
                             bus.id_br_result ? bus.id_target : (bus.id_pc + PC_W'(4));
    assign bus.mispred_cnt = cnt_q;

    // Update path: existing entry trains its counter, a miss allocates fresh
    assign id_idx  = bus.id_pc[IDX_W+1:2];
    assign id_tag  = bus.id_pc[PC_W-1:IDX_W+2];
    assign id_hit  = vld_q[id_idx] && (tag_q[id_idx] == id_tag);
    assign ctr_new = id_hit ? ctr_upd : (bus.id_br_result ? WT : WNT);

    bp_sat_ctr2 u_sat_ctr (
        .ctr     (ctr_e'(ctr_q[id_idx])),
        .taken   (bus.id_br_result),
        .ctr_nxt (ctr_upd)
    );

    // BTB write on each resolved branch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            tag_q <= '0;
            tgt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
        end else if (resolve) begin
            vld_q[id_idx] <= 1'b1;
            tag_q[id_idx] <= id_tag;
            tgt_q[id_idx] <= bus.id_target;
            ctr_q[id_idx] <= ctr_new;
        end
    end

    // IF->ID prediction register: hold on stall, bubble on flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            pred_q <= '0;
        else if (!bus.ifid_stall)
            pred_q <= redirect ? pred_t'('0) : pred_t'{pred_taken, pred_target};
    end

    // Saturating mispredict counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_q <= '0;
        else if (redirect && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a per-cycle vector table covers
// training, aliasing and target mismatch; hand sequences cover stall,
// counter saturation and asynchronous reset.
module tb_branch_predict_unit;

    localparam logic [31:0] A  = 32'h0040_0010;
    localparam logic [31:0] A4 = 32'h0040_0014;
    localparam logic [31:0] T  = 32'h0040_0040;
    localparam logic [31:0] B  = 32'h0080_0010;
    localparam logic [31:0] TB = 32'h0080_0080;
    localparam logic [31:0] TC = 32'h0080_0100;
    localparam logic [31:0] TD = 32'h0040_0400;
    localparam int NV = 17;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.PC_W(32), .CNT_W(16)) bus ();

    branch_predict_unit #(.PC_W(32), .IDX_W(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] if_pc;
        logic        vld;
        logic [31:0] id_pc;
        logic [31:0] id_tgt;
        logic        res;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_rd;
        logic [31:0] e_rpc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [NV];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [15:0] exp_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic [31:0] pc, input logic st, input logic v,
                         input logic [31:0] ipc, input logic [31:0] itg, input logic r);
        bus.if_pc        = pc;
        bus.ifid_stall   = st;
        bus.id_br_valid  = v;
        bus.id_pc        = ipc;
        bus.id_target    = itg;
        bus.id_br_result = r;
    endtask

    initial begin
        //            if_pc vld id_pc id_tgt res | pt ptgt  rd rpc  cnt
        vecs[0]  = '{A,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0};
        vecs[1]  = '{A4, 1'b1, A,     T,     1'b1, 1'b0, 32'h0, 1'b1, T,     16'd0};
        vecs[2]  = '{A,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, T,     1'b0, 32'h0, 16'd1};
        vecs[3]  = '{A4, 1'b1, A,     T,     1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 16'd1};
        vecs[4]  = '{A,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, T,     1'b0, 32'h0, 16'd1};
        vecs[5]  = '{A4, 1'b1, A,     T,     1'b0, 1'b0, 32'h0, 1'b1, A4,    16'd1};
        vecs[6]  = '{A,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, T,     1'b0, 32'h0, 16'd2};
        vecs[7]  = '{A4, 1'b1, A,     T,     1'b0, 1'b0, 32'h0, 1'b1, A4,    16'd2};
        vecs[8]  = '{A,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd3};
        vecs[9]  = '{A4, 1'b1, A,     T,     1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd3};
        vecs[10] = '{B,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd3};
        vecs[11] = '{A4, 1'b1, B,     TB,    1'b1, 1'b0, 32'h0, 1'b1, TB,    16'd3};
        vecs[12] = '{B,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, TB,    1'b0, 32'h0, 16'd4};
        vecs[13] = '{A,  1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd4};
        vecs[14] = '{B,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, TB,    1'b0, 32'h0, 16'd4};
        vecs[15] = '{B,  1'b1, B,     TC,    1'b1, 1'b1, TB,    1'b1, TC,    16'd4};
        vecs[16] = '{B,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, TC,    1'b0, 32'h0, 16'd5};

        rstn = 1'b0;
        drive(A, 1'b0, 1'b1, A, T, 1'b1);
        #12;
        chk("rst_pred_taken",  {31'h0, bus.pred_taken}, 32'h0);
        chk("rst_pred_target", bus.pred_target, 32'h0);
        chk("rst_redirect",    {31'h0, bus.redirect}, 32'h0);
        chk("rst_flush",       {31'h0, bus.flush_ifid}, 32'h0);
        chk("rst_cnt",         {16'h0, bus.mispred_cnt}, 32'h0);
        drive(A, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Table: one vector per cycle
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].if_pc, 1'b0, vecs[i].vld, vecs[i].id_pc, vecs[i].id_tgt, vecs[i].res);
            @(negedge clk);
            chk($sformatf("v%0d_pred_taken", i), {31'h0, bus.pred_taken}, {31'h0, vecs[i].e_pt});
            if (vecs[i].e_pt)
                chk($sformatf("v%0d_pred_target", i), bus.pred_target, vecs[i].e_ptgt);
            chk($sformatf("v%0d_redirect", i), {31'h0, bus.redirect}, {31'h0, vecs[i].e_rd});
            chk($sformatf("v%0d_flush", i), {31'h0, bus.flush_ifid}, {31'h0, vecs[i].e_rd});
            if (vecs[i].e_rd)
                chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].e_rpc);
            chk($sformatf("v%0d_cnt", i), {16'h0, bus.mispred_cnt}, {16'h0, vecs[i].e_cnt});
        end

        // Stalled branch: held 3 cycles, nothing resolves
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            drive(B, 1'b1, 1'b1, A, TD, 1'b1);
            @(negedge clk);
            chk($sformatf("stall%0d_redirect", s), {31'h0, bus.redirect}, 32'h0);
            chk($sformatf("stall%0d_flush", s), {31'h0, bus.flush_ifid}, 32'h0);
            chk($sformatf("stall%0d_cnt", s), {16'h0, bus.mispred_cnt}, 32'd5);
            chk($sformatf("stall%0d_pred_target", s), bus.pred_target, TC);
        end
        @(posedge clk); #1;
        drive(A4, 1'b0, 1'b1, A, TD, 1'b1);
        @(negedge clk);
        chk("release_redirect",    {31'h0, bus.redirect}, 32'h1);
        chk("release_redirect_pc", bus.redirect_pc, TD);
        @(posedge clk); #1;
        drive(A, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("release_cnt_once", {16'h0, bus.mispred_cnt}, 32'd6);
        chk("release_pred_taken", {31'h0, bus.pred_taken}, 32'h1);
        chk("release_pred_target", bus.pred_target, TD);
        @(posedge clk); #1;
        drive(B, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("evicted_pred_taken", {31'h0, bus.pred_taken}, 32'h0);

        // Saturation: a taken branch against a flushed (not-taken) prediction
        // mispredicts every cycle
        exp_cnt = 16'd6;
        while (exp_cnt != 16'hFFFF) begin
            @(posedge clk); #1;
            drive(32'h0000_1000, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1);
            exp_cnt = exp_cnt + 16'd1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("sat_reach_ffff", {16'h0, bus.mispred_cnt}, 32'h0000_FFFF);
        chk("sat_redirect",   {31'h0, bus.redirect}, 32'h1);
        chk("sat_pred_taken", {31'h0, bus.pred_taken}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sat_hold_ffff", {16'h0, bus.mispred_cnt}, 32'h0000_FFFF);

        // Asynchronous reset mid-cycle while a mispredict is pending
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("arst_pred_taken",  {31'h0, bus.pred_taken}, 32'h0);
        chk("arst_pred_target", bus.pred_target, 32'h0);
        chk("arst_redirect",    {31'h0, bus.redirect}, 32'h0);
        chk("arst_flush",       {31'h0, bus.flush_ifid}, 32'h0);
        chk("arst_redirect_pc", bus.redirect_pc, 32'h0);
        chk("arst_cnt",         {16'h0, bus.mispred_cnt}, 32'h0);
        @(negedge clk);
        drive(32'h0000_1000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("arst_btb_invalid", {31'h0, bus.pred_taken}, 32'h0);
        chk("arst_cnt_after",   {16'h0, bus.mispred_cnt}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
